// File: rtl/usb_pkg.sv
// Shared types and USB constants for the transmit sequencer and its CRC generator.
package usb_pkg;

   typedef enum logic [1:0] {
      PKT_HANDSHAKE = 2'b00,
      PKT_TOKEN     = 2'b01,
      PKT_DATA      = 2'b10,
      PKT_RESERVED  = 2'b11
   } pkt_type_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SYNC,
      ST_PID,
      ST_ADDR,
      ST_ENDP,
      ST_CRC5,
      ST_DATA,
      ST_CRC16,
      ST_EOP
   } seq_state_t;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;

   // Indexed by bit position, so bit 0 is the first bit on the wire.
   localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

   localparam logic [4:0]  CRC5_POLY  = 5'b00101;
   localparam logic [4:0]  CRC5_INIT  = 5'h1F;
   localparam logic [15:0] CRC16_POLY = 16'h8005;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   function automatic logic [6:0] field_len(input seq_state_t s);
      case (s)
         ST_SYNC:  return 7'd8;
         ST_PID:   return 7'd8;
         ST_ADDR:  return 7'd7;
         ST_ENDP:  return 7'd4;
         ST_CRC5:  return 7'd5;
         ST_DATA:  return 7'd64;
         ST_CRC16: return 7'd16;
         default:  return 7'd1;
      endcase
   endfunction

   function automatic seq_state_t next_field(input seq_state_t s, input pkt_type_t t);
      case (s)
         ST_SYNC: return ST_PID;
         ST_PID: begin
            if (t == PKT_TOKEN) return ST_ADDR;
            if (t == PKT_DATA)  return ST_DATA;
            return ST_EOP;
         end
         ST_ADDR: return ST_ENDP;
         ST_ENDP: return ST_CRC5;
         ST_DATA: return ST_CRC16;
         default: return ST_EOP;
      endcase
   endfunction

endpackage

// File: rtl/usb_tx_sequencer_if.sv
// Request, bit-stream and status signals between the protocol FSM, the sequencer and the stuffer.
interface usb_tx_sequencer_if;

   logic        start;
   logic [1:0]  pkt_type;
   logic [3:0]  pid;
   logic [6:0]  addr;
   logic [3:0]  endp;
   logic [63:0] data;
   logic        pause;
   logic        bit_out;
   logic        bit_valid;
   logic        do_eop;
   logic        busy;
   logic        done;

   modport master (
      output start, pkt_type, pid, addr, endp, data, pause,
      input  bit_out, bit_valid, do_eop, busy, done
   );

   modport slave (
      input  start, pkt_type, pid, addr, endp, data, pause,
      output bit_out, bit_valid, do_eop, busy, done
   );

endinterface

// File: rtl/usb_crc_gen.sv
// Serial USB CRC generator; mode=1 selects CRC16, mode=0 selects CRC5 (returned in the low bits).
module usb_crc_gen
   import usb_pkg::*;
(
   input  logic        clk,
   input  logic        rst_L,
   input  logic        clear,
   input  logic        en,
   input  logic        mode,
   input  logic        din,
   output logic [15:0] crc
);

   logic [4:0]  crc5;
   logic [15:0] crc16;
   logic        fb5;
   logic        fb16;

   assign fb5  = crc5[4] ^ din;
   assign fb16 = crc16[15] ^ din;

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         crc5  <= CRC5_INIT;
         crc16 <= CRC16_INIT;
      end else if (clear) begin
         crc5  <= CRC5_INIT;
         crc16 <= CRC16_INIT;
      end else if (en) begin
         if (mode) crc16 <= {crc16[14:0], 1'b0} ^ (fb16 ? CRC16_POLY : 16'h0000);
         else      crc5  <= {crc5[3:0], 1'b0} ^ (fb5 ? CRC5_POLY : 5'b00000);
      end
   end

   assign crc = mode ? crc16 : {11'b0, crc5};

endmodule

// File: rtl/usb_tx_sequencer.sv
// Latches one packet request and serialises SYNC/PID/fields/CRC as NRZ bits, then requests EOP.
module usb_tx_sequencer
   import usb_pkg::*;
(
   input  logic               clk,
   input  logic               rst_L,
   usb_tx_sequencer_if.slave  bus
);

   seq_state_t  state, state_nxt;
   logic [6:0]  bit_cnt, cnt_nxt;
   logic        done_q, done_nxt;
   pkt_type_t   pkt_q;
   logic [3:0]  pid_q;
   logic [6:0]  addr_q;
   logic [3:0]  endp_q;
   logic [63:0] data_q;
   logic        accept;
   logic        bit_o, bit_valid, do_eop, busy, done;
   logic        crc_en;
   logic [15:0] crc_rem;
   logic [3:0]  crc5_idx, crc16_idx;

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         done_q  <= 1'b0;
         pkt_q   <= PKT_HANDSHAKE;
         pid_q   <= '0;
         addr_q  <= '0;
         endp_q  <= '0;
         data_q  <= '0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= cnt_nxt;
         done_q  <= done_nxt;
         if (accept) begin
            pkt_q  <= pkt_type_t'(bus.pkt_type);
            pid_q  <= bus.pid;
            addr_q <= bus.addr;
            endp_q <= bus.endp;
            data_q <= bus.data;
         end
      end
   end

   // CRC fields go out MSB first, so the index counts down from the top bit.
   always_comb begin
      crc5_idx  = 4'd4 - bit_cnt[3:0];
      crc16_idx = 4'd15 - bit_cnt[3:0];
      case (state)
         ST_SYNC:  bit_o = SYNC_PATTERN[bit_cnt[2:0]];
         ST_PID:   bit_o = bit_cnt[2] ? ~pid_q[bit_cnt[1:0]] : pid_q[bit_cnt[1:0]];
         ST_ADDR:  bit_o = addr_q[bit_cnt[2:0]];
         ST_ENDP:  bit_o = endp_q[bit_cnt[1:0]];
         ST_CRC5:  bit_o = ~crc_rem[crc5_idx];
         ST_DATA:  bit_o = data_q[bit_cnt[5:0]];
         ST_CRC16: bit_o = ~crc_rem[crc16_idx];
         default:  bit_o = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = bit_cnt;
      done_nxt  = 1'b0;
      accept    = 1'b0;
      bit_valid = 1'b0;
      do_eop    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      crc_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            done = done_q;
            if (bus.start && bus.pkt_type != PKT_RESERVED) begin
               accept    = 1'b1;
               state_nxt = ST_SYNC;
               cnt_nxt   = '0;
            end
         end
         ST_EOP: begin
            busy = 1'b1;
            // A pause right after the last bit is the stuffer's trailing stuff bit; wait it out.
            if (!(bit_cnt == 7'd0 && bus.pause)) begin
               do_eop = 1'b1;
               if (bit_cnt == 7'd2) begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = '0;
                  done_nxt  = 1'b1;
               end else begin
                  cnt_nxt = bit_cnt + 7'd1;
               end
            end
         end
         default: begin
            busy      = 1'b1;
            bit_valid = 1'b1;
            if (!bus.pause) begin
               crc_en  = (state == ST_ADDR) || (state == ST_ENDP) || (state == ST_DATA);
               cnt_nxt = bit_cnt + 7'd1;
               if (bit_cnt == field_len(state) - 7'd1) begin
                  cnt_nxt   = '0;
                  state_nxt = next_field(state, pkt_q);
               end
            end
         end
      endcase
   end

   usb_crc_gen u_crc (
      .clk   (clk),
      .rst_L (rst_L),
      .clear (accept),
      .en    (crc_en),
      .mode  (pkt_q == PKT_DATA),
      .din   (bit_o),
      .crc   (crc_rem)
   );

   assign bus.bit_out   = bit_o;
   assign bus.bit_valid = bit_valid;
   assign bus.do_eop    = do_eop;
   assign bus.busy      = busy;
   assign bus.done      = done;

endmodule
